// File: rtl/mult_test_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_test_pkg
//  Description : Shared types and constants for the multiplier test sequencer.
//                - seq_state_t     : sequencer state enumeration
//                - DEFAULT_LATENCY : fixed multiplier datapath latency (cycles)
//                - run_len_width() : width needed to hold a run length of
//                                    0..2^addr_width operations
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int DEFAULT_LATENCY = 20;

    // A run of 2^addr_width operations needs one bit more than an address.
    function automatic int run_len_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage : mult_test_pkg
`default_nettype wire

// File: rtl/wr_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : wr_tag_pipe
//  Description : LATENCY-deep shift register of {valid, addr} write tags.
//                Stage 0 loads the incoming tag every cycle; the last stage
//                is the registered output. A synchronous flush clears every
//                valid bit (addresses are don't-care once invalid).
//  Ports       : clock      - rising-edge clock
//                resetn     - asynchronous active-low reset
//                flush      - synchronous clear of all valid bits
//                in_valid   - tag valid into stage 0
//                in_addr    - tag address into stage 0
//                out_valid  - valid bit of the last stage
//                out_addr   - address of the last stage
//                any_valid  - a tag is still held upstream of the last stage
//  Revision    : 1.0 - initial release
// ============================================================================
module wr_tag_pipe
    import mult_test_pkg::*;
#(
    parameter int LATENCY    = DEFAULT_LATENCY,   // must be >= 1
    parameter int ADDR_WIDTH = 8
)(
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  any_valid
);

    logic [LATENCY-1:0]    vld;
    logic [ADDR_WIDTH-1:0] adr [LATENCY];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                adr[i] <= '0;
            end
        end else begin
            if (flush) begin
                vld <= '0;
            end else begin
                vld[0] <= in_valid;
                for (int i = 1; i < LATENCY; i++) begin
                    vld[i] <= vld[i-1];
                end
            end
            adr[0] <= in_addr;
            for (int i = 1; i < LATENCY; i++) begin
                adr[i] <= adr[i-1];
            end
        end
    end

    assign out_valid = vld[LATENCY-1];
    assign out_addr  = adr[LATENCY-1];

    // The last stage's write completes in the current cycle, so only the
    // stages behind it still represent outstanding work.
    generate
        if (LATENCY > 1) begin : g_multi_stage
            assign any_valid = |vld[LATENCY-2:0];
        end else begin : g_single_stage
            assign any_valid = 1'b0;
        end
    endgenerate

endmodule : wr_tag_pipe
`default_nettype wire

// File: rtl/mult_test_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mult_test_sequencer
//  Description : Runs one multiplier test pass over the shared test RAMs:
//                bursts operand read addresses, delays a write tag by the
//                datapath latency to drive the result RAM, and exposes a
//                start/busy/done handshake, PLL-lock supervision and a run
//                cycle counter.
//  Options     : SEQ_LOOP_EN - adds the 'loop' input; while it is high at the
//                last address of a pass, ISSUE restarts from address 0.
//  Ports       : clock       - rising-edge clock
//                resetn      - asynchronous active-low reset
//                start       - level; a 0->1 edge in IDLE launches a run
//                abort       - synchronous abort request
//                pll_lock    - PLL lock status (already synchronised)
//                loop        - (SEQ_LOOP_EN only) repeat the address pass
//                num_ops     - operations per run, 0..2^ADDR_WIDTH
//                rd_en/rd_addr - operand read strobe / address
//                wr_en/wr_addr - result write strobe / address
//                busy        - run in ISSUE or DRAIN
//                done        - sticky, run completed normally
//                err_lock    - sticky, run refused or killed by lock loss
//                cycle_count - ISSUE+DRAIN cycles of the last run, saturating
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_test_sequencer
    import mult_test_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = DEFAULT_LATENCY,   // must be >= 1
    parameter int CNT_WIDTH  = 32
)(
    input  logic                                 clock,
    input  logic                                 resetn,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic                                 pll_lock,
`ifdef SEQ_LOOP_EN
    input  logic                                 loop,
`endif
    input  logic [run_len_width(ADDR_WIDTH)-1:0] num_ops,
    output logic                                 rd_en,
    output logic [ADDR_WIDTH-1:0]                rd_addr,
    output logic                                 wr_en,
    output logic [ADDR_WIDTH-1:0]                wr_addr,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err_lock,
    output logic [CNT_WIDTH-1:0]                 cycle_count
);

    localparam int NW = run_len_width(ADDR_WIDTH);

    seq_state_t            state;
    logic                  start_d;
    logic [NW-1:0]         ops_q;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic                  loop_req;
    logic                  kill;
    logic                  pending;

`ifdef SEQ_LOOP_EN
    assign loop_req = loop;
`else
    assign loop_req = 1'b0;
`endif

    // For a full-size run (2^ADDR_WIDTH) the truncation yields all-ones.
    assign last_addr = ADDR_WIDTH'(ops_q - NW'(1));

    // Abort or lock loss while a run is active tears everything down in the
    // same edge: state, read strobe and every in-flight write tag.
    assign kill = busy & (abort | ~pll_lock);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            start_d     <= 1'b0;
            ops_q       <= '0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_lock    <= 1'b0;
            cycle_count <= '0;
        end else begin
            start_d <= start;
            case (state)
                IDLE: begin
                    if (start && !start_d) begin
                        if (pll_lock) begin
                            err_lock    <= 1'b0;
                            cycle_count <= '0;
                            ops_q       <= num_ops;
                            rd_addr     <= '0;
                            if (num_ops == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= ISSUE;
                                done  <= 1'b0;
                                rd_en <= 1'b1;
                                busy  <= 1'b1;
                            end
                        end else begin
                            err_lock <= 1'b1;
                        end
                    end
                end

                ISSUE, DRAIN: begin
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + CNT_WIDTH'(1);
                    end
                    if (kill) begin
                        state <= IDLE;
                        rd_en <= 1'b0;
                        busy  <= 1'b0;
                        if (!pll_lock) begin
                            err_lock <= 1'b1;
                        end
                    end else if (state == ISSUE) begin
                        if (rd_addr == last_addr && loop_req) begin
                            rd_addr <= '0;
                        end else if (rd_addr == last_addr) begin
                            state   <= DRAIN;
                            rd_en   <= 1'b0;
                            rd_addr <= rd_addr + ADDR_WIDTH'(1);
                        end else begin
                            rd_addr <= rd_addr + ADDR_WIDTH'(1);
                        end
                    end else if (!pending) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    wr_tag_pipe #(
        .LATENCY    (LATENCY),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr_tag_pipe (
        .clock     (clock),
        .resetn    (resetn),
        .flush     (kill),
        .in_valid  (rd_en),
        .in_addr   (rd_addr),
        .out_valid (wr_en),
        .out_addr  (wr_addr),
        .any_valid (pending)
    );

endmodule : mult_test_sequencer
`default_nettype wire

// File: tb/tb_mult_test_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_test_sequencer
//  Description : Self-checking bench for mult_test_sequencer. Each run's
//                expected read/write streams, done timing, err_lock and
//                cycle_count are derived arithmetically from the run
//                parameters and compared with logged DUT activity.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_test_sequencer;

    localparam int AW  = 8;
    localparam int LAT = 20;
    localparam int CW  = 32;

    logic          clock    = 1'b0;
    logic          resetn   = 1'b0;
    logic          start    = 1'b0;
    logic          abort    = 1'b0;
    logic          pll_lock = 1'b1;
`ifdef SEQ_LOOP_EN
    logic          loop     = 1'b0;
`endif
    logic [AW:0]   num_ops  = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          busy;
    logic          done;
    logic          err_lock;
    logic [CW-1:0] cycle_count;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int rd_t[$];
    int rd_a[$];
    int wr_t[$];
    int wr_a[$];

    mult_test_sequencer #(
        .ADDR_WIDTH (AW),
        .LATENCY    (LAT),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .abort       (abort),
        .pll_lock    (pll_lock),
`ifdef SEQ_LOOP_EN
        .loop        (loop),
`endif
        .num_ops     (num_ops),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .busy        (busy),
        .done        (done),
        .err_lock    (err_lock),
        .cycle_count (cycle_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Outputs are logged mid-cycle, away from the active edge.
    always @(negedge clock) begin
        if (rd_en) begin
            rd_t.push_back(cyc);
            rd_a.push_back(int'(rd_addr));
        end
        if (wr_en) begin
            wr_t.push_back(cyc);
            wr_a.push_back(int'(wr_addr));
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rd_t.delete();
        rd_a.delete();
        wr_t.delete();
        wr_a.delete();
    endtask

    // mode 0: normal run (optionally looping for loop_cycles issue cycles)
    // mode 1: abort asserted during run cycle k
    // mode 2: pll_lock low during run cycle k
    task automatic run(input int n, input int mode, input int k, input int loop_cycles);
        int launch, exp_rd, exp_wr, exp_cnt, exp_done_t, done_t, t, window;
        if (mode == 0) begin
            exp_rd = n;
            // loop is sampled on the last address of each pass
            if (n > 0) begin
                while (exp_rd - 1 < loop_cycles) exp_rd += n;
            end
            exp_wr     = exp_rd;
            exp_cnt    = (n == 0) ? 0 : exp_rd + LAT;
            exp_done_t = (n == 0) ? 0 : exp_rd + LAT;
        end else begin
            exp_rd = (k + 1 < n) ? k + 1 : n;
            // writes landing up to and including the kill cycle are seen
            exp_wr = k - LAT + 1;
            if (exp_wr < 0) exp_wr = 0;
            if (exp_wr > n) exp_wr = n;
            exp_cnt    = k + 1;
            exp_done_t = -1;
        end

        @(negedge clock);
        clear_logs();
        num_ops = (AW+1)'(n);
        start   = 1'b1;
        launch  = cyc + 1;
        done_t  = -1;
        window  = exp_rd + LAT + 40;
        for (int i = 0; i < window; i++) begin
            @(negedge clock);
            t = cyc - launch;
            // a second start edge while busy must be ignored
            start    = (mode == 0 && n > 0 && t == 3);
            abort    = (mode == 1 && t == k);
            pll_lock = !(mode == 2 && t == k);
`ifdef SEQ_LOOP_EN
            loop     = (t < loop_cycles);
`endif
            if (done && done_t < 0) done_t = t;
            if (mode != 0 && t == k + 1) begin
                chk("busy_after_kill", busy, 0);
                chk("rd_en_after_kill", rd_en, 0);
            end
        end
        start    = 1'b0;
        abort    = 1'b0;
        pll_lock = 1'b1;

        chk("rd_count", rd_t.size(), exp_rd);
        for (int i = 0; i < rd_t.size() && i < exp_rd; i++) begin
            chk($sformatf("rd_addr[%0d]", i), rd_a[i], i % n);
            chk($sformatf("rd_time[%0d]", i), rd_t[i] - launch, i);
        end
        chk("wr_count", wr_t.size(), exp_wr);
        for (int i = 0; i < wr_t.size() && i < exp_wr; i++) begin
            chk($sformatf("wr_addr[%0d]", i), wr_a[i], i % n);
            chk($sformatf("wr_time[%0d]", i), wr_t[i] - launch, i + LAT);
        end
        chk("done", done, (mode == 0) ? 1 : 0);
        chk("done_time", done_t, exp_done_t);
        chk("err_lock", err_lock, (mode == 2) ? 1 : 0);
        chk("busy_end", busy, 0);
        chk("cycle_count", cycle_count, exp_cnt);
    endtask

    initial begin
        int n, k, m;

        // ---- reset state ----
        repeat (3) @(negedge clock);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_lock", err_lock, 0);
        chk("rst_cycle_count", cycle_count, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        // ---- basic run ----
        run(5, 0, 0, 0);

        // ---- start edge while PLL unlocked: refused, err_lock set ----
        @(negedge clock);
        clear_logs();
        pll_lock = 1'b0;
        num_ops  = 9'd7;
        start    = 1'b1;
        repeat (3) @(negedge clock);
        start    = 1'b0;
        chk("nolock_err_lock", err_lock, 1);
        chk("nolock_busy", busy, 0);
        chk("nolock_rd_count", rd_t.size(), 0);
        chk("nolock_done_sticky", done, 1);
        pll_lock = 1'b1;
        @(negedge clock);

        // ---- boundaries: empty run and full-size run ----
        run(0, 0, 0, 0);
        run(256, 0, 0, 0);

        // ---- lock loss at the third issue cycle ----
        run(10, 2, 2, 0);

        // ---- abort during DRAIN, then a clean restart ----
        run(12, 1, 12 + 5, 0);
        run(3, 0, 0, 0);

        // ---- randomized normal runs ----
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 60);
            run(n, 0, 0, 0);
        end

        // ---- randomized abort / lock-loss runs ----
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 40);
            k = $urandom_range(0, n + LAT - 1);
            m = $urandom_range(1, 2);
            run(n, m, k, 0);
        end

`ifdef SEQ_LOOP_EN
        // ---- looping ----
        run(4, 0, 0, 10);
        run($urandom_range(2, 9), 0, 0, $urandom_range(5, 30));
`endif

        // ---- asynchronous reset mid-run ----
        @(negedge clock);
        num_ops = 9'd30;
        start   = 1'b1;
        repeat (25) @(negedge clock);
        start   = 1'b0;
        resetn  = 1'b0;
        #1;
        chk("amid_rd_en", rd_en, 0);
        chk("amid_wr_en", wr_en, 0);
        chk("amid_busy", busy, 0);
        chk("amid_cycle_count", cycle_count, 0);
        chk("amid_done", done, 0);
        @(negedge clock);
        resetn = 1'b1;
        clear_logs();
        repeat (40) @(negedge clock);
        chk("post_rst_wr_count", wr_t.size(), 0);
        chk("post_rst_rd_count", rd_t.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mult_test_sequencer
`default_nettype wire

// File: doc/mult_test_sequencer.md
Name: mult_test_sequencer

Overview:
- Controls one multiplier test run on the shared single-port test RAMs.
- Issues a burst of operand read addresses (one per cycle) to the operand RAMs.
- Carries a write tag (valid bit plus address) through a delay line that matches the fixed multiplier datapath latency, then drives result-RAM write enable and address.
- Supplies start/busy/done handshake, PLL-lock supervision and a run cycle counter to the Avalon-side test control registers.

Parameters:
- ADDR_WIDTH, 8, width of the RAM address; maximum run length is 2^ADDR_WIDTH operations.
- LATENCY, 20, cycles from rd_en/rd_addr to the matching wr_en/wr_addr. Must be at least 1.
- CNT_WIDTH, 32, width of cycle_count.

Ports:
- clock  in  1  sequencer clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  level; a 0->1 edge in IDLE launches a run.
- abort  in  1  synchronous abort request.
- pll_lock  in  1  PLL lock status, already synchronised to clock.
- num_ops  in  ADDR_WIDTH+1  operations per run; valid range 0..2^ADDR_WIDTH.
- rd_en  out  1  operand read strobe.
- rd_addr  out  ADDR_WIDTH  operand read address.
- wr_en  out  1  result write strobe.
- wr_addr  out  ADDR_WIDTH  result write address.
- busy  out  1  high in ISSUE or DRAIN.
- done  out  1  sticky; run completed normally.
- err_lock  out  1  sticky; run killed by loss of PLL lock.
- cycle_count  out  CNT_WIDTH  cycles spent in ISSUE plus DRAIN for the last run.

Behaviour:
- Reset values: all outputs 0, state IDLE, all delay-line valid bits 0.
- States:
  - IDLE
    - On a start rising edge with pll_lock=1: clear done, err_lock and cycle_count; latch num_ops.
    - If num_ops=0, go to DONE. Otherwise go to ISSUE.
    - A start edge with pll_lock=0 sets err_lock and stays in IDLE.
  - ISSUE
    - rd_en=1 every cycle; rd_addr starts at 0 and increments by 1 each cycle.
    - After the cycle that issues address num_ops-1, go to DRAIN.
    - When num_ops=2^ADDR_WIDTH, the last address is all-ones; rd_addr wraps to 0 afterwards, with no extra issue.
  - DRAIN
    - rd_en=0. Stay until every delay-line valid bit is 0, then go to DONE.
  - DONE
    - Set done=1 for one cycle as the state is entered, then go to IDLE. done stays set afterwards.
- Delay line: LATENCY registers of {valid, addr}. Stage 0 loads {rd_en, rd_addr}. wr_en/wr_addr are the last stage, registered.
  - Exactly one wr_en per issued read, LATENCY cycles later, in issue order.
- cycle_count increments every cycle in ISSUE or DRAIN and holds afterwards. It saturates at all-ones.
- abort in ISSUE or DRAIN:
  - rd_en drops in the same cycle the state returns to IDLE.
  - All delay-line valid bits clear, so no further wr_en.
  - done stays 0 and err_lock is unchanged.
- pll_lock=0 in ISSUE or DRAIN: same as abort, and err_lock is set.
- Simultaneous abort and lock loss: err_lock is set.
- start edges while busy are ignored. The start edge detector keeps running in every state.
- Asynchronous reset mid-run: immediate return to reset values; no wr_en pulses afterwards.

Optional Feature:
- Macro: SEQ_LOOP_EN.
- Defined:
  - Adds input port loop (1 bit).
  - In ISSUE, if loop=1 when address num_ops-1 is issued, rd_addr wraps to 0 and ISSUE continues.
  - Looping ends by deasserting loop, in which case the current pass finishes and the block drains. It also ends on abort or lock loss.
  - cycle_count keeps counting, saturating.
- Undefined: no loop port; behaviour is identical to loop=0.

Decomposition:
- Package mult_test_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN, DONE);
  - the DEFAULT_LATENCY constant;
  - the run-length width helper.
- Sub-module wr_tag_pipe: parameterised LATENCY-deep {valid, addr} shift register with a synchronous flush input and an any_valid output. It is reused for the positive and negative clock-phase controllers.

Test Plan:
- num_ops=5, LATENCY=20, pll_lock=1, start pulse -> rd_en high for 5 cycles with rd_addr 0..4; wr_en high 20 cycles after each read with wr_addr 0..4; done=1; cycle_count=25.
- num_ops=0, start -> no rd_en, no wr_en, done=1 after 1 cycle, cycle_count=0.
- num_ops=256, ADDR_WIDTH=8 -> 256 issues with rd_addr 0..255; wr_addr ends at 255; exactly 256 wr_en pulses; cycle_count=276.
- num_ops=10, pll_lock driven to 0 at the third issue cycle -> rd_en stops, no wr_en afterwards, err_lock=1, done=0, busy=0 next cycle.
- abort during DRAIN, then restart with num_ops=3 -> first run writes nothing further; second run yields wr_addr 0,1,2 and done=1, with err_lock remaining 0.
- SEQ_LOOP_EN defined, num_ops=4, loop=1 for 10 issue cycles, then loop=0 -> rd_addr sequence 0,1,2,3,0,1,2,3,0,1,2,3; 12 wr_en pulses; done=1.
